// File: rtl/cacheline_adaptor_if.sv
// Cache-line side and memory-burst side of the cacheline adaptor.
// The master modport is the cache/memory environment; the slave modport is the adaptor.
interface cacheline_adaptor_if #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64
);
   // cache side
   logic                   read_i;
   logic                   write_i;
   logic [31:0]            address_i;
   logic [LINE_WIDTH-1:0]  line_i;
   logic [LINE_WIDTH-1:0]  line_o;
   logic                   resp_o;
   // memory side
   logic                   read_o;
   logic                   write_o;
   logic [31:0]            address_o;
   logic [BURST_WIDTH-1:0] burst_o;
   logic [BURST_WIDTH-1:0] burst_i;
   logic                   resp_i;

   modport master (
      output read_i, write_i, address_i, line_i, burst_i, resp_i,
      input  line_o, resp_o, read_o, write_o, address_o, burst_o
   );

   modport slave (
      input  read_i, write_i, address_i, line_i, burst_i, resp_i,
      output line_o, resp_o, read_o, write_o, address_o, burst_o
   );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one full-line cache request into a four-beat memory burst (write)
// or gathers a four-beat memory burst into a full line (read).
module cacheline_adaptor #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64
) (
   input  logic                clk,
   input  logic                rst,
   cacheline_adaptor_if.slave  bus
);
   localparam int BEATS    = LINE_WIDTH / BURST_WIDTH;
   localparam int CNT_W    = $clog2(BEATS);
   localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
   localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
   localparam logic [31:0]      ALIGN_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic [CNT_W-1:0]      r_count;
   logic [31:0]           r_addr;
   logic [LINE_WIDTH-1:0] r_line;
   logic [LINE_WIDTH-1:0] r_line_o;
   logic [31:0]           w_beat_base;
   logic                  w_last_beat;

   assign w_beat_base = 32'(r_count) * BURST_WIDTH;
   assign w_last_beat = bus.resp_i && (r_count == LAST_BEAT);

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   // NOTE: defaulting every comb output first keeps the block free of inferred latches.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (bus.write_i)     w_state_next = WRITE;
            else if (bus.read_i) w_state_next = READ;
         end
         READ, WRITE: if (w_last_beat) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // NOTE: the line stores are plain flops rather than a RAM, so they take the reset too.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= '0;
         r_addr   <= '0;
         r_line   <= '0;
         r_line_o <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.write_i) begin
                  r_addr  <= bus.address_i & ALIGN_MASK;
                  r_line  <= bus.line_i;
                  r_count <= '0;
               end else if (bus.read_i) begin
                  r_addr  <= bus.address_i & ALIGN_MASK;
                  r_count <= '0;
               end
            end
            READ: begin
               if (bus.resp_i) begin
                  r_line_o[w_beat_base +: BURST_WIDTH] <= bus.burst_i;
                  r_count <= r_count + 1'b1;
               end
            end
            WRITE: if (bus.resp_i) r_count <= r_count + 1'b1;
            default: ;
         endcase
      end
   end

   // Moore outputs: decoded only from registered state, never from the inputs.
   always_comb begin
      bus.read_o    = 1'b0;
      bus.write_o   = 1'b0;
      bus.resp_o    = 1'b0;
      bus.address_o = '0;
      bus.burst_o   = '0;
      case (r_state)
         READ: begin
            bus.read_o    = 1'b1;
            bus.address_o = r_addr;
         end
         WRITE: begin
            bus.write_o   = 1'b1;
            bus.address_o = r_addr;
            bus.burst_o   = r_line[w_beat_base +: BURST_WIDTH];
         end
         DONE: begin
            bus.resp_o    = 1'b1;
            bus.address_o = r_addr;
         end
         default: ;
      endcase
   end

   assign bus.line_o = r_line_o;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: a per-cycle vector table, directed
// corner-case transactions and randomized transactions against a beat-count model.
module tb_cacheline_adaptor;
   localparam int LW = 256;
   localparam int BW = 64;
   localparam int NB = LW / BW;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic clk = 1'b0;
   logic rst;

   cacheline_adaptor_if #(.LINE_WIDTH(LW), .BURST_WIDTH(BW)) bus ();
   cacheline_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [LW-1:0] model_line;

   typedef struct {
      logic          rst, rd, wr, resp;
      logic [31:0]   addr;
      logic [BW-1:0] burst;
      logic          exp_rd, exp_wr, exp_resp, chk_addr;
      logic [31:0]   exp_addr;
      logic [LW-1:0] exp_line;
   } vec_t;

   vec_t vecs[11];

   function automatic logic [BW-1:0] beat(input logic [3:0] n);
      return {16{n}};
   endfunction

   function automatic logic [31:0] align(input logic [31:0] a);
      return {a[31:5], 5'b0};
   endfunction

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic vec_t mk(input logic r, input logic rd, input logic wr, input logic rs,
                               input logic [31:0] a, input logic [BW-1:0] b,
                               input logic erd, input logic ewr, input logic ers,
                               input logic ca, input logic [31:0] ea, input logic [LW-1:0] el);
      vec_t v;
      v.rst = r; v.rd = rd; v.wr = wr; v.resp = rs; v.addr = a; v.burst = b;
      v.exp_rd = erd; v.exp_wr = ewr; v.exp_resp = ers; v.chk_addr = ca;
      v.exp_addr = ea; v.exp_line = el;
      return v;
   endfunction

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic rd, input logic wr, input logic resp,
                             input bit chk_addr, input logic [31:0] addr,
                             input bit chk_burst, input logic [BW-1:0] burst,
                             input logic [LW-1:0] line);
      check({tag, " read_o"},  LW'(bus.read_o),  LW'(rd));
      check({tag, " write_o"}, LW'(bus.write_o), LW'(wr));
      check({tag, " resp_o"},  LW'(bus.resp_o),  LW'(resp));
      if (chk_addr)  check({tag, " address_o"}, LW'(bus.address_o), LW'(addr));
      if (chk_burst) check({tag, " burst_o"},   LW'(bus.burst_o),   LW'(burst));
      check({tag, " line_o"}, bus.line_o, line);
   endtask

   task automatic idle(input string tag);
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      bus.resp_i  = 1'($urandom_range(1));
      bus.burst_i = {$urandom, $urandom};
      step();
      expect_out(tag, L, L, L, 1'b1, 32'h0, 1'b0, '0, model_line);
   endtask

   // One cache transaction; expectations come from counting accepted beats.
   task automatic run_txn(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [LW-1:0] wline, input logic [LW-1:0] rline,
                          input bit from_done, input bit wiggle, input int gap_pct,
                          input int pat_len, input logic [15:0] pat);
      bit            is_wr   = wr;
      logic [LW-1:0] partial = model_line;
      int            k       = 0;
      int            c       = 0;
      logic          r;
      bus.read_i    = rd;
      bus.write_i   = wr;
      bus.address_i = addr;
      bus.line_i    = wline;
      bus.resp_i    = 1'b0;
      bus.burst_i   = {$urandom, $urandom};
      if (from_done) begin
         step();
         expect_out({tag, " idle gap"}, L, L, L, 1'b1, 32'h0, 1'b0, '0, model_line);
      end
      step();
      expect_out({tag, " accept"}, !is_wr, is_wr, L, 1'b1, align(addr), is_wr, wline[BW-1:0], partial);
      while (k < NB) begin
         if (c < pat_len)  r = pat[c];
         else if (c >= 40) r = 1'b1;
         else              r = ($urandom_range(99) >= gap_pct);
         bus.resp_i  = r;
         bus.burst_i = r ? rline[k*BW +: BW] : {$urandom, $urandom};
         if (wiggle) begin
            bus.read_i    = 1'($urandom_range(1));
            bus.write_i   = 1'($urandom_range(1));
            bus.address_i = $urandom;
            bus.line_i    = rand_line();
         end
         step();
         c++;
         if (r) begin
            if (!is_wr) partial[k*BW +: BW] = rline[k*BW +: BW];
            k++;
         end
         if (k < NB)
            expect_out({tag, " beat"}, !is_wr, is_wr, L, 1'b1, align(addr), is_wr, wline[k*BW +: BW], partial);
         else
            expect_out({tag, " done"}, L, L, H, 1'b0, 32'h0, 1'b0, '0, partial);
      end
      model_line  = partial;
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      bus.resp_i  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LW-1:0] p1, p2, p3, p4, wl;
      p1 = {192'd0, beat(4'h1)};
      p2 = {128'd0, beat(4'h2), beat(4'h1)};
      p3 = {64'd0, beat(4'h3), beat(4'h2), beat(4'h1)};
      p4 = {beat(4'h4), beat(4'h3), beat(4'h2), beat(4'h1)};

      // reset with busy inputs, resp_i in IDLE, then a contiguous read of 0x1234
      vecs[0]  = mk(H, H, H, H, 32'hFFFF_FFFF, beat(4'hF), L, L, L, H, 32'h0,    '0);
      vecs[1]  = mk(H, L, H, H, 32'h1234_5678, beat(4'hE), L, L, L, H, 32'h0,    '0);
      vecs[2]  = mk(L, L, L, H, 32'h0,         beat(4'h5), L, L, L, H, 32'h0,    '0);
      vecs[3]  = mk(L, L, L, H, 32'h0,         beat(4'h6), L, L, L, H, 32'h0,    '0);
      vecs[4]  = mk(L, H, L, L, 32'h1234,      beat(4'h7), H, L, L, H, 32'h1220, '0);
      vecs[5]  = mk(L, H, L, H, 32'h1234,      beat(4'h1), H, L, L, H, 32'h1220, p1);
      vecs[6]  = mk(L, H, L, H, 32'h1234,      beat(4'h2), H, L, L, H, 32'h1220, p2);
      vecs[7]  = mk(L, H, L, H, 32'h1234,      beat(4'h3), H, L, L, H, 32'h1220, p3);
      vecs[8]  = mk(L, H, L, H, 32'h1234,      beat(4'h4), L, L, H, L, 32'h0,    p4);
      vecs[9]  = mk(L, L, L, L, 32'h0,         beat(4'h8), L, L, L, H, 32'h0,    p4);
      vecs[10] = mk(L, L, L, H, 32'h0,         beat(4'h9), L, L, L, H, 32'h0,    p4);

      bus.line_i = '0;
      for (int i = 0; i < 11; i++) begin
         rst           = vecs[i].rst;
         bus.read_i    = vecs[i].rd;
         bus.write_i   = vecs[i].wr;
         bus.resp_i    = vecs[i].resp;
         bus.address_i = vecs[i].addr;
         bus.burst_i   = vecs[i].burst;
         step();
         expect_out($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_wr, vecs[i].exp_resp,
                    vecs[i].chk_addr, vecs[i].exp_addr, 1'b0, '0, vecs[i].exp_line);
         if (vecs[i].rst) check($sformatf("vec%0d burst_o", i), LW'(bus.burst_o), '0);
      end
      model_line = p4;

      // gapped write, resp_i pattern 1,0,0,1,1,0,1 (bit 0 first)
      wl = {beat(4'hD), beat(4'hC), beat(4'hB), beat(4'hA)};
      run_txn("gapped_wr", L, H, 32'h0000_ABCD, wl, '0, 1'b0, 1'b0, 0, 7, 16'h0059);
      idle("gapped_wr post");

      // both requests high: write has priority
      run_txn("both_req", H, H, 32'h0000_0300, rand_line(), '0, 1'b0, 1'b0, 20, 0, 16'h0);
      idle("both_req post");

      // reset after two read beats
      bus.read_i    = 1'b1;
      bus.address_i = 32'h0000_0200;
      bus.resp_i    = 1'b0;
      step();
      expect_out("rst_mid accept", H, L, L, 1'b1, 32'h200, 1'b0, '0, model_line);
      for (int b = 0; b < 2; b++) begin
         bus.resp_i  = 1'b1;
         bus.burst_i = beat(4'(5 + b));
         model_line[b*BW +: BW] = beat(4'(5 + b));
         step();
         expect_out("rst_mid beat", H, L, L, 1'b1, 32'h200, 1'b0, '0, model_line);
      end
      rst           = 1'b1;
      bus.read_i    = 1'($urandom_range(1));
      bus.write_i   = 1'($urandom_range(1));
      bus.resp_i    = 1'b1;
      bus.address_i = $urandom;
      step();
      model_line = '0;
      expect_out("rst_mid reset", L, L, L, 1'b1, 32'h0, 1'b1, '0, model_line);
      rst = 1'b0;
      idle("rst_mid idle");
      run_txn("after_rst", H, L, 32'h0000_0208, '0, rand_line(), 1'b0, 1'b0, 0, 0, 16'h0);
      idle("after_rst post");

      // back-to-back: write 0x40, then read 0x80 reissued in the DONE cycle
      run_txn("b2b_wr", L, H, 32'h0000_0040, rand_line(), '0, 1'b0, 1'b0, 0, 0, 16'h0);
      run_txn("b2b_rd", H, L, 32'h0000_0080, '0, rand_line(), 1'b1, 1'b0, 0, 0, 16'h0);
      idle("b2b post");

      // randomized transactions with request wiggle mid-burst
      for (int t = 0; t < 25; t++) begin
         int   op;
         logic rd, wr;
         bit   chain;
         op    = $urandom_range(2);
         rd    = (op != 1);
         wr    = (op != 0);
         chain = 1'($urandom_range(1));
         if (!chain) idle($sformatf("rnd%0d pre", t));
         run_txn($sformatf("rnd%0d", t), rd, wr, $urandom, rand_line(), rand_line(),
                 chain, 1'b1, 35, 0, 16'h0);
      end
      idle("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
